// File: rtl/io_input_port.sv
// rtl/io_input_port.sv - IO-page input port: switch/button sync, debounce, press events, irq
// Registers at 0xff90-0xff9f: SW, KEY, EVT (clear-on-read), STATUS, IRQEN.

module io_input_port #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_IO_re,
    input  logic        i_IO_we,
    input  logic [7:0]  i_IO_addr,
    input  logic [15:0] i_IO_data,
    input  logic [9:0]  i_sw,
    input  logic [3:0]  i_key,
    output logic [15:0] o_IO_data,
    output logic        o_IO_rvalid,
    output logic        o_irq
);

    localparam int          NBITS    = 14;
    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    localparam logic [7:0] ADDR_SW     = 8'h90;
    localparam logic [7:0] ADDR_KEY    = 8'h91;
    localparam logic [7:0] ADDR_EVT    = 8'h92;
    localparam logic [7:0] ADDR_STATUS = 8'h93;
    localparam logic [7:0] ADDR_IRQEN  = 8'h94;

    // Bits [9:0] are switches, [13:10] are keys already flipped to 1 = pressed.
    logic [NBITS-1:0]       sync1;
    logic [NBITS-1:0]       sync2;
    logic [NBITS-1:0]       deb;
    logic [NBITS-1:0]       deb_next;
    logic [NBITS-1:0][15:0] cnt;
    logic [NBITS-1:0][15:0] cnt_next;

    logic [3:0]  evt;
    logic [3:0]  evt_next;
    logic [3:0]  key_rise;
    logic [3:0]  irq_en;
    logic        in_window;
    logic        rd_hit;
    logic        evt_clr;
    logic        irqen_wr;
    logic [15:0] rd_data;
    logic        unused_wdata;

    assign unused_wdata = ^i_IO_data[15:4];

    // A differing sample that reverts before the count completes restarts from zero.
    always_comb begin
        deb_next = deb;
        cnt_next = cnt;
        for (int i = 0; i < NBITS; i++) begin
            if (sync2[i] == deb[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                deb_next[i] = sync2[i];
                cnt_next[i] = '0;
            end else begin
                cnt_next[i] = cnt[i] + 16'd1;
            end
        end
    end

    assign key_rise  = deb_next[13:10] & ~deb[13:10];
    assign in_window = (i_IO_addr[7:4] == 4'h9);
    assign rd_hit    = i_IO_re && in_window;
    assign evt_clr   = rd_hit && (i_IO_addr == ADDR_EVT);
    assign irqen_wr  = i_IO_we && (i_IO_addr == ADDR_IRQEN);

    // A press landing on the same edge as the clearing read survives.
    assign evt_next = (evt & ~{4{evt_clr}}) | key_rise;

    always_comb begin
        rd_data = '0;
        case (i_IO_addr)
            ADDR_SW:     rd_data = {6'd0, deb[9:0]};
            ADDR_KEY:    rd_data = {12'd0, deb[13:10]};
            ADDR_EVT:    rd_data = {12'd0, evt};
            ADDR_STATUS: rd_data = {14'd0, o_irq, |evt};
            ADDR_IRQEN:  rd_data = {12'd0, irq_en};
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= {~i_key, i_sw};
            sync2 <= sync1;
            deb   <= deb_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            evt         <= '0;
            irq_en      <= '0;
            o_irq       <= 1'b0;
            o_IO_rvalid <= 1'b0;
            o_IO_data   <= '0;
        end else begin
            evt         <= evt_next;
            if (irqen_wr) begin
                irq_en <= i_IO_data[3:0];
            end
            o_irq       <= |(evt & irq_en);
            o_IO_rvalid <= rd_hit;
            o_IO_data   <= rd_hit ? rd_data : 16'd0;
        end
    end

endmodule

// File: doc/io_input_port.md
# io_input_port

Memory-mapped input peripheral for the CPU's IO page: the read-side counterpart of the hex display output port. It synchronizes and debounces the board slide switches and push-buttons, latches button-press events, and returns register contents to the CPU on IO reads in the 0xff90–0xff9f window. It also drives a level interrupt request when enabled press events are pending.

## Interface
- DEBOUNCE_CYCLES, 16: cycles a synchronized input must differ stably from its debounced value before the debounced value updates. Range 2..65535; use 50000 on the board.
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- i_IO_re  in  1  CPU IO read strobe.
- i_IO_we  in  1  CPU IO write strobe.
- i_IO_addr  in  8  low byte of IO address (page 0xff00).
- i_IO_data  in  16  CPU write data.
- i_sw  in  10  raw slide switches, active-high, asynchronous.
- i_key  in  4  raw push-buttons, active-low (0 = pressed), asynchronous.
- o_IO_data  out  16  read data, registered.
- o_IO_rvalid  out  1  read data valid, one-cycle pulse.
- o_irq  out  1  interrupt request, level.

## Operation
- Input path, per bit (14 bits: 10 sw, 4 key inverted to active-high pressed): 2-flop synchronizer -> debouncer.
- Debouncer per bit: counter cnt (16 bits). If sync == deb: cnt <= 0. Else if cnt == DEBOUNCE_CYCLES-1: deb <= sync, cnt <= 0. Else cnt <= cnt+1. Any glitch back to deb value restarts the count.
- Press event: key_deb[i] rising (0->1 in the debounced pressed domain) sets evt[i] in the same edge deb updates. Releases do not set events.
- Register map (i_IO_addr):
  - 0x90 SW: [9:0] = sw_deb, [15:10] = 0. RO.
  - 0x91 KEY: [3:0] = key_deb (1 = held), rest 0. RO.
  - 0x92 EVT: [3:0] = evt, rest 0. Clear-on-read.
  - 0x93 STATUS: [0] = |evt, [1] = o_irq, rest 0. RO.
  - 0x94 IRQEN: [3:0] = irq_en. RW; write loads i_IO_data[3:0].
  - 0x95–0x9f: read 0, writes ignored.
- Addresses outside 0x90–0x9f: reads produce no rvalid, o_IO_data 0; writes ignored.
- o_irq = |(evt & irq_en), registered.
- Reset (reset == 0 at a clock edge): synchronizers, deb, cnt, evt, irq_en all 0; o_IO_data = 0, o_IO_rvalid = 0, o_irq = 0. Reset mid-debounce discards partial count; a held key after reset produces a press event once debounced (deb starts at 0).

## Timing
- Read: i_IO_re=1 with in-window address at edge N -> o_IO_data and o_IO_rvalid=1 valid after edge N (sampled at edge N+1), data reflects register state before edge N. Cycles without in-window read: o_IO_data = 0, o_IO_rvalid = 0.
- Back-to-back reads on consecutive cycles supported; rvalid stays high.
- EVT clear-on-read: evt clears at the read edge. A new press event setting bit i at the same edge survives (set wins over clear), and is returned by the next read.
- i_IO_re and i_IO_we both high same cycle: both take effect; read of 0x94 returns old irq_en.
- Pin-to-deb latency: 2 synchronizer cycles + DEBOUNCE_CYCLES cycles of stable input.
- o_irq updates one cycle after evt or irq_en changes.
- cnt never exceeds DEBOUNCE_CYCLES-1; no wrap.

## Test plan
- Reset: hold reset=0 3 cycles with i_sw=0x3ff, i_key=0x0 -> all outputs 0; after release, read 0x90 at settle returns 0x03ff, 0x91 returns 0x000f, 0x92 returns 0x000f.
- Debounce (DEBOUNCE_CYCLES=4): toggle i_sw[0] 0->1 for 3 cycles then back -> sw_deb unchanged; hold 1 steady -> 0x90 reads 0x0001 exactly 6 cycles after the pin change.
- Event + clear-on-read: press key2 (i_key=4'b1011) stable -> read 0x92 returns 0x0004, immediate second read returns 0x0000; release generates no event.
- Set-wins collision: arrange key1 deb rising at the same edge as a read of 0x92 with evt=0x1 -> read returns 0x0001, next read returns 0x0002.
- IRQ: write 0x94 = 0x0002, press key0 -> o_irq stays 0; press key1 -> o_irq=1 one cycle after evt[1] set; read 0x92 -> o_irq=0 one cycle after evt clears.
- Address decode: reads at 0x8f, 0xa0 -> o_IO_rvalid=0, data 0; read 0x9a -> rvalid=1, data 0x0000; write 0x90 -> no effect.
